// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MIPS pipeline MEM stage with an on-chip 32-bit data RAM.
//               Handles byte/halfword/word loads and stores with sign or zero
//               extension, and uses a valid/ready request handshake with a
//               registered response one cycle after accept. A rate-limited
//               debug read path shares the RAM and drives the board LEDs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W       word-address width, RAM depth = 2**ADDR_W words
//   DBG_ADDR_W   debug word-address width (<= ADDR_W, zero-extended)
//   LED_W        LED width, LEDs show the low LED_W bits of the debug word
//   DBG_REFRESH  cycles between debug re-reads (>= 2)
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (accept = valid & ready)
//   req_we                   1 = store, 0 = load
//   req_size                 00 byte, 01 half, 1x word
//   req_unsigned             zero-extend loads
//   req_addr, req_wdata      byte address, right-justified store data
//   rsp_valid, rsp_rdata     one-cycle response pulse and extended load data
//   misalign                 sticky misaligned-access flag
//   dbg_en, dbg_addr, led    debug display mode, word address, LED output
// Configuration macro
//   MEM_MISALIGN_TRAP_EN     when defined, misaligned half/word accesses are
//                            suppressed and flagged; otherwise the low address
//                            bits are forced aligned and misalign reads 0.
// ============================================================================
module mem_stage_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int DBG_ADDR_W  = 6,
    parameter int LED_W       = 8,
    parameter int DBG_REFRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  misalign,
    input  logic                  dbg_en,
    input  logic [DBG_ADDR_W-1:0] dbg_addr,
    output logic [LED_W-1:0]      led
);

    localparam int                c_depth  = 2 ** ADDR_W;
    localparam int                c_cnt_w  = $clog2(DBG_REFRESH);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DBG_REFRESH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DBG  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------
    logic [31:0]        r_mem [0:c_depth-1];
    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic [LED_W-1:0]   r_led;

    // ------------------------------------------------------------------
    // Combinational request decode
    // ------------------------------------------------------------------
    logic               w_req_ready;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_dbg_idx;
    logic [1:0]         w_lo;
    logic               w_suppress;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_lanes;
    logic               w_store;
    logic [31:0]        w_rd_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;
    logic [31:0]        w_rsp_data;
    logic [LED_W-1:0]   w_dbg_led;
    logic               w_unused_addr;

    assign w_accept  = req_valid & w_req_ready;
    assign w_idx     = req_addr[ADDR_W+1:2];
    assign w_dbg_idx = ADDR_W'(dbg_addr);

    // Address bits above the RAM depth are ignored, so accesses wrap.
    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned = ((req_size == 2'b01) & req_addr[0]) |
                          (req_size[1] & (|req_addr[1:0]));
    assign w_lo         = req_addr[1:0];
    assign w_suppress   = w_misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_accept & w_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    // Without trapping, the offending low bits are simply dropped.
    always_comb begin
        w_lo = 2'b00;
        case (req_size)
            2'b00:   w_lo = req_addr[1:0];
            2'b01:   w_lo = {req_addr[1], 1'b0};
            default: w_lo = 2'b00;
        endcase
    end

    assign w_suppress = 1'b0;
    assign misalign   = 1'b0;
`endif

    // Byte-lane enables and replicated store data so each lane sees the
    // right-justified source bytes.
    always_comb begin
        w_be          = 4'b0000;
        w_wdata_lanes = req_wdata;
        case (req_size)
            2'b00: begin
                w_be          = 4'b0001 << w_lo;
                w_wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be          = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_wdata_lanes = req_wdata;
            end
        endcase
    end

    assign w_store = w_accept & req_we & ~w_suppress;

    // ------------------------------------------------------------------
    // Data RAM: written on the accept edge, read combinationally so a load
    // accepted right after a store to the same word sees the new data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];
    assign w_dbg_led = r_mem[w_dbg_idx][LED_W-1:0];

    // Little-endian lane select followed by sign/zero extension.
    always_comb begin
        w_byte      = w_rd_word[8*w_lo +: 8];
        w_half      = w_lo[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        w_load_data = w_rd_word;
        case (req_size)
            2'b00:   w_load_data = req_unsigned ? {24'h000000, w_byte}
                                                : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = req_unsigned ? {16'h0000, w_half}
                                                : {{16{w_half[15]}}, w_half};
            default: w_load_data = w_rd_word;
        endcase
    end

    assign w_rsp_data = (req_we | w_suppress) ? 32'h0000_0000 : w_load_data;

    // ------------------------------------------------------------------
    // Arbitration FSM: the pipeline always wins; a debug read only slips in
    // on an idle cycle once the refresh counter has run out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Held low during reset so no store can land while in reset.
                w_req_ready = ~rst;
                if (dbg_en & ~req_valid & (r_cnt == '0)) begin
                    w_state_next = S_DBG;
                end
            end
            S_DBG: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign req_ready = w_req_ready;

    // Refresh counter: reloads when a debug read starts, otherwise counts
    // down to zero and waits there until the bus is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!dbg_en) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) && (w_state_next == S_DBG)) begin
            r_cnt <= c_reload;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response and LED registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_rdata <= w_rsp_data;
            end
        end
    end

    // Leaving debug mode blanks the LEDs even if a read is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else if (!dbg_en) begin
            r_led <= '0;
        end else if (r_state == S_DBG) begin
            r_led <= w_dbg_led;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. Expected responses are
//               queued when a request is driven and compared when the
//               response pulse appears one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int ADDR_W      = 7;
    localparam int DBG_ADDR_W  = 6;
    localparam int LED_W       = 8;
    localparam int DBG_REFRESH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [1:0]            req_size = 2'b10;
    logic                  req_unsigned = 1'b0;
    logic [31:0]           req_addr = 32'h0;
    logic [31:0]           req_wdata = 32'h0;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  misalign;
    logic                  dbg_en = 1'b0;
    logic [DBG_ADDR_W-1:0] dbg_addr = '0;
    logic [LED_W-1:0]      led;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } op_t;

    logic [31:0] sb [$];

    mem_stage_ctrl #(
        .ADDR_W      (ADDR_W),
        .DBG_ADDR_W  (DBG_ADDR_W),
        .LED_W       (LED_W),
        .DBG_REFRESH (DBG_REFRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .misalign     (misalign),
        .dbg_en       (dbg_en),
        .dbg_addr     (dbg_addr),
        .led          (led)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp);
        op_t o;
        o.we = we; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata; o.exp = exp;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        req_valid    = 1'b1;
        req_we       = o.we;
        req_size     = o.size;
        req_unsigned = o.uns;
        req_addr     = o.addr;
        req_wdata    = o.wdata;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h expected 00", led); end
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    endtask

    // ------------------------------------------------------------------
    // Stores and loads issued back to back; req_ready must never drop.
    task automatic test_back_to_back();
        op_t         ops [$];
        logic [31:0] exp;
        logic [31:0] last;
        ops.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10,  32'h8081_F2F3, 32'h0));
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0, 32'h8081_F2F3));
        ops.push_back(mk(1'b0, 2'b00, 1'b0, 32'h11,  32'h0, 32'hFFFF_FFF2));
        ops.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13,  32'h0, 32'h0000_0080));
        ops.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12,  32'h0, 32'hFFFF_8081));
        ops.push_back(mk(1'b0, 2'b01, 1'b1, 32'h10,  32'h0, 32'h0000_F2F3));
        ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'h12,  32'h0000_00AA, 32'h0));
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0, 32'h80AA_F2F3));
        ops.push_back(mk(1'b1, 2'b11, 1'b0, 32'h04,  32'h1122_3344, 32'h0));
        ops.push_back(mk(1'b1, 2'b01, 1'b0, 32'h06,  32'h0000_BEEF, 32'h0));
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h04,  32'h0, 32'hBEEF_3344));
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h210, 32'h0, 32'h80AA_F2F3));
        ops.push_back(mk(1'b0, 2'b00, 1'b0, 32'h07,  32'h0, 32'hFFFF_FFBE));
        last = 32'hFFFF_FFBE;
        for (int i = 0; i <= ops.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: valid=%b rdata=%h, expected valid=1 rdata=%h", i-1, rsp_valid, rsp_rdata, exp);
                end
            end
            if (i < ops.size()) begin
                n_checks++;
                if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
                drive_op(ops[i]);
                sb.push_back(ops[i].exp);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== last) begin
            n_fail++;
            $display("FAIL b2b_idle_hold: valid=%b rdata=%h, expected valid=0 rdata=%h", rsp_valid, rsp_rdata, last);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_misalign();
        op_t         ops [$];
        logic [31:0] exp;
        logic        exp_flag;
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pre: got %b expected 0", misalign); end
`ifdef MEM_MISALIGN_TRAP_EN
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0));
        ops.push_back(mk(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5555, 32'h0));
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80AA_F2F3));
        exp_flag = 1'b1;
`else
        ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'hBEEF_3344));
        ops.push_back(mk(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'hFFFF_80AA));
        exp_flag = 1'b0;
`endif
        for (int i = 0; i <= ops.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL misalign_rsp[%0d]: valid=%b rdata=%h, expected valid=1 rdata=%h", i-1, rsp_valid, rsp_rdata, exp);
                end
            end
            if (i < ops.size()) begin
                drive_op(ops[i]);
                sb.push_back(ops[i].exp);
            end else begin
                req_valid = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (misalign !== exp_flag) begin n_fail++; $display("FAIL misalign_flag: got %b expected %b", misalign, exp_flag); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_debug();
        op_t         ops [$];
        logic [31:0] exp;
        logic        found;
        dbg_addr = 6'd4;
        dbg_en   = 1'b1;
        found    = 1'b0;
        for (int c = 0; c < DBG_REFRESH + 2 && !found; c++) begin
            @(negedge clk);
            if (led === 8'hF3) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL dbg_led_first: got %h expected F3", led); end

        // Continuous traffic starting on the idle cycle after the debug read.
        ops.push_back(mk(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077, 32'h0));
        for (int k = 0; k < 6; k++) ops.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80AA_F277));
        for (int i = 0; i <= ops.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL dbg_traffic_rsp[%0d]: valid=%b rdata=%h, expected valid=1 rdata=%h", i-1, rsp_valid, rsp_rdata, exp);
                end
            end
            if (i < ops.size()) begin
                n_checks++;
                if (req_ready !== 1'b1) begin n_fail++; $display("FAIL dbg_traffic_ready[%0d]: got %b expected 1", i, req_ready); end
                drive_op(ops[i]);
                sb.push_back(ops[i].exp);
            end else begin
                req_valid = 1'b0;
            end
        end

        // Bus now free: the pending refresh should show the new byte.
        found = 1'b0;
        for (int c = 0; c < DBG_REFRESH + 2 && !found; c++) begin
            @(negedge clk);
            if (led === 8'h77) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL dbg_led_refresh: got %h expected 77", led); end

        dbg_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL dbg_led_off: got %h expected 00", led); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_access();
        logic found;
        dbg_addr = 6'd4;
        dbg_en   = 1'b1;
        found    = 1'b0;
        for (int c = 0; c < DBG_REFRESH + 2 && !found; c++) begin
            @(negedge clk);
            if (led === 8'h77) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rstmid_led_setup: got %h expected 77", led); end
        drive_op(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0));
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got %b expected 1", rsp_valid); end
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        dbg_en    = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rsp_rdata: got %h expected 00000000", rsp_rdata); end
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL rstmid_led: got %h expected 00", led); end
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL rstmid_misalign: got %b expected 0", misalign); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
        drive_op(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0));
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80AA_F277) begin
            n_fail++;
            $display("FAIL rstmid_ram_retained: valid=%b rdata=%h, expected valid=1 rdata=80aaf277", rsp_valid, rsp_rdata);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_back_to_back();
        test_misalign();
        test_debug();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
